// File: rtl/cache_transfer_ctrl.sv
// cache_transfer_ctrl: miss-service FSM sequencing optional write-back then refill bursts
module cache_transfer_ctrl #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_miss_req,
  input  logic                      i_dirty,
  input  logic [AXI_ADDR_WIDTH-1:0] i_victim_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                      i_axi_beat_done,
  input  logic                      i_count_done,
  input  logic                      i_axi_error,
  output logic                      o_start_write,
  output logic                      o_start_read,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr_cache,
  output logic                      o_block_we,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error
);
  localparam int OFF = $clog2(BLOCK_WIDTH / 8);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WB, GAP, REFILL, INSTALL, ERR} state_e;
  state_e state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] victim_q, victim_d, miss_q, miss_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic xfer, tmo, accept;
  always_comb begin
    xfer = state_q == WB || state_q == REFILL;
    tmo = xfer && !i_axi_beat_done && tmo_q == TMAX;
    accept = state_q == IDLE && i_miss_req;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_miss_req ? (i_dirty ? WB : REFILL) : IDLE;
      WB:      state_d = i_axi_error ? ERR : i_count_done ? GAP : tmo ? ERR : WB;
      GAP:     state_d = REFILL;
      REFILL:  state_d = i_axi_error ? ERR : i_count_done ? INSTALL : tmo ? ERR : REFILL;
      default: state_d = IDLE;
    endcase
    victim_d = accept ? {i_victim_addr[AXI_ADDR_WIDTH-1:OFF], {OFF{1'b0}}} : victim_q;
    miss_d = accept ? {i_miss_addr[AXI_ADDR_WIDTH-1:OFF], {OFF{1'b0}}} : miss_q;
    // the per-beat watchdog restarts on every beat and on every state change
    tmo_d = (!xfer || i_axi_beat_done || state_d != state_q) ? '0 : tmo_q + 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      miss_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      miss_q   <= miss_d;
      tmo_q    <= tmo_d;
    end
  end
  assign o_start_write = state_q == WB;
  assign o_start_read  = state_q == REFILL;
  assign o_addr_cache  = state_q == WB ? victim_q : state_q == REFILL ? miss_q : '0;
  assign o_block_we    = state_q == INSTALL;
  assign o_done        = state_q == INSTALL;
  assign o_error       = state_q == ERR;
  assign o_busy        = state_q != IDLE;
endmodule

// File: tb/tb_cache_transfer_ctrl.sv
// tb_cache_transfer_ctrl: scoreboard bench for the miss-service FSM
module tb_cache_transfer_ctrl;
  localparam int T = 256;
  typedef enum {SI, SW, SG, SR, SN, SX} st_e;
  logic clk = 0, arst = 0;
  logic miss_req = 0, dirty = 0, beat = 0, cnt = 0, err = 0;
  logic [63:0] vaddr = 0, maddr = 0, addr;
  logic sw, sr, bwe, busy, done, error;
  logic [69:0] sb[$];
  int npass = 0, ntot = 0;
  string phase = "reset";
  cache_transfer_ctrl dut (
    .i_clk(clk), .i_arst(arst), .i_miss_req(miss_req), .i_dirty(dirty),
    .i_victim_addr(vaddr), .i_miss_addr(maddr), .i_axi_beat_done(beat),
    .i_count_done(cnt), .i_axi_error(err), .o_start_write(sw), .o_start_read(sr),
    .o_addr_cache(addr), .o_block_we(bwe), .o_busy(busy), .o_done(done), .o_error(error)
  );
  always #5 clk = ~clk;
  function automatic logic [69:0] ev(input st_e s, input logic [63:0] a);
    return {s == SW, s == SR, s == SN, s != SI, s == SN, s == SX, a};
  endfunction
  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h (wr,rd,we,busy,done,err,addr)", tag, got, exp);
  endtask
  task automatic tick(input st_e s, input logic [63:0] a);
    sb.push_back(ev(s, a));
    @(posedge clk);
    #1 check(phase, {sw, sr, bwe, busy, done, error, addr}, sb.pop_front());
  endtask
  task automatic burst(input st_e s, input logic [63:0] a, input st_e last, input int n);
    for (int i = 0; i < n; i++) begin
      beat = 1;
      cnt = i == n - 1;
      if (i == n - 1) tick(last, 0);
      else tick(s, a);
      beat = 0;
      cnt = 0;
      if (i % 5 == 2 && i != n - 1) tick(s, a);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset", {sw, sr, bwe, busy, done, error, addr}, '0);
    arst = 1;
    phase = "idle_ignore";
    beat = 1; cnt = 1; err = 1;
    tick(SI, 0);
    beat = 0; cnt = 0; err = 0;
    phase = "clean";
    miss_req = 1; dirty = 0; vaddr = 64'hDEAD_BEEF; maddr = 64'h1047;
    tick(SR, 64'h1040);
    burst(SR, 64'h1040, SN, 16);
    miss_req = 0;
    tick(SI, 0);
    phase = "dirty";
    miss_req = 1; dirty = 1; vaddr = 64'h2FFF; maddr = 64'h3001;
    tick(SW, 64'h2FC0);
    dirty = 0;
    burst(SW, 64'h2FC0, SG, 16);
    tick(SR, 64'h3000);
    burst(SR, 64'h3000, SN, 16);
    miss_req = 0;
    tick(SI, 0);
    phase = "error";
    miss_req = 1; maddr = 64'h4080;
    tick(SR, 64'h4080);
    beat = 1;
    repeat (4) tick(SR, 64'h4080);
    cnt = 1; err = 1;
    tick(SX, 0);
    beat = 0; cnt = 0; err = 0; miss_req = 0;
    tick(SI, 0);
    tick(SI, 0);
    phase = "timeout";
    miss_req = 1; maddr = 64'h5000;
    tick(SR, 64'h5000);
    beat = 1;
    repeat (3) tick(SR, 64'h5000);
    beat = 0;
    repeat (T - 1) tick(SR, 64'h5000);
    tick(SX, 0);
    miss_req = 0;
    tick(SI, 0);
    phase = "beat_at_threshold";
    miss_req = 1; maddr = 64'h5100;
    tick(SR, 64'h5100);
    beat = 1;
    tick(SR, 64'h5100);
    beat = 0;
    repeat (T - 1) tick(SR, 64'h5100);
    beat = 1;
    tick(SR, 64'h5100);
    cnt = 1;
    tick(SN, 0);
    beat = 0; cnt = 0; miss_req = 0;
    tick(SI, 0);
    phase = "reset_mid_wb";
    miss_req = 1; dirty = 1; vaddr = 64'h2FFF; maddr = 64'h3001;
    tick(SW, 64'h2FC0);
    beat = 1;
    repeat (7) tick(SW, 64'h2FC0);
    #1 arst = 0;
    #1 check("async_reset", {sw, sr, bwe, busy, done, error, addr}, '0);
    beat = 0;
    @(posedge clk);
    #1 check("reset_held", {sw, sr, bwe, busy, done, error, addr}, '0);
    arst = 1;
    tick(SW, 64'h2FC0);
    burst(SW, 64'h2FC0, SG, 16);
    tick(SR, 64'h3000);
    burst(SR, 64'h3000, SN, 16);
    phase = "back_to_back";
    dirty = 0; maddr = 64'h6010;
    tick(SI, 0);
    tick(SR, 64'h6000);
    burst(SR, 64'h6000, SN, 16);
    maddr = 64'h7ABC;
    tick(SI, 0);
    tick(SR, 64'h7A80);
    burst(SR, 64'h7A80, SN, 8);
    miss_req = 0;
    tick(SI, 0);
    tick(SI, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
